// File: rtl/seq_pkg.sv
// Shared types, width helpers and default control words for the microsequencer.
package seq_pkg;

   typedef enum logic [1:0] {
      FETCH0 = 2'd0,
      FETCH1 = 2'd1,
      EXEC   = 2'd2,
      HALT   = 2'd3
   } seq_state_e;

   localparam logic [15:0] DEF_IDLE_WORD   = 16'h0FFF;
   localparam logic [15:0] DEF_FETCH0_WORD = 16'h0BF7;
   localparam logic [15:0] DEF_FETCH1_WORD = 16'h1DFF;

   function automatic int step_w_f(input int max_steps);
      return $clog2(max_steps);
   endfunction

   // Execute-step index width; never collapses below one bit for 3-step builds.
   function automatic int ustep_w_f(input int max_steps);
      int w;
      w = $clog2(max_steps - 32'sd2);
      return (w < 32'sd1) ? 32'sd1 : w;
   endfunction

endpackage

// File: rtl/microsequencer_if.sv
// Sequencer <-> IR/flags/ROM/datapath bundle; SEQ_SINGLE_STEP_EN adds STEP_MODE.
interface microsequencer_if #(
   parameter int OPCODE_W  = 4,
   parameter int CTRL_W    = 16,
   parameter int MAX_STEPS = 6
);
   import seq_pkg::*;

   localparam int STEP_W  = step_w_f(MAX_STEPS);
   localparam int USTEP_W = ustep_w_f(MAX_STEPS);
   localparam int UADDR_W = OPCODE_W + 2 + USTEP_W;

   logic [OPCODE_W-1:0] OPCODE;
   logic                CF;
   logic                ZF;
   logic [UADDR_W-1:0]  UADDR;
   logic [CTRL_W-1:0]   UWORD;
   logic                UEND;
   logic                UHLT;
   logic                RESUME;
   logic [CTRL_W-1:0]   CTRL;
   logic                T0;
   logic                HALTED;
   logic [STEP_W-1:0]   STEP;

`ifdef SEQ_SINGLE_STEP_EN
   logic                STEP_MODE;

   modport master (
      input  OPCODE, CF, ZF, UWORD, UEND, UHLT, RESUME, STEP_MODE,
      output UADDR, CTRL, T0, HALTED, STEP
   );
   modport slave (
      output OPCODE, CF, ZF, UWORD, UEND, UHLT, RESUME, STEP_MODE,
      input  UADDR, CTRL, T0, HALTED, STEP
   );
`else
   modport master (
      input  OPCODE, CF, ZF, UWORD, UEND, UHLT, RESUME,
      output UADDR, CTRL, T0, HALTED, STEP
   );
   modport slave (
      output OPCODE, CF, ZF, UWORD, UEND, UHLT, RESUME,
      input  UADDR, CTRL, T0, HALTED, STEP
   );
`endif

endinterface

// File: rtl/seq_step_counter.sv
// T-state counter clocked on the falling edge; clear wins over enable.
module seq_step_counter #(
   parameter int WIDTH = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: clear, increment or hold
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + WIDTH'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register
   always_ff @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/microsequencer.sv
// Fetch/execute/halt microsequencer driving the datapath control word from an async ROM.
// Optional single-instruction stepping is enabled by defining SEQ_SINGLE_STEP_EN.
module microsequencer
   import seq_pkg::*;
#(
   parameter int              OPCODE_W    = 4,
   parameter int              CTRL_W      = 16,
   parameter int              MAX_STEPS   = 6,
   parameter logic [CTRL_W-1:0] IDLE_WORD   = CTRL_W'(DEF_IDLE_WORD),
   parameter logic [CTRL_W-1:0] FETCH0_WORD = CTRL_W'(DEF_FETCH0_WORD),
   parameter logic [CTRL_W-1:0] FETCH1_WORD = CTRL_W'(DEF_FETCH1_WORD)
) (
   input  logic             CLK,
   input  logic             RESETn,
   microsequencer_if.master bus
);

   localparam int                STEP_W    = step_w_f(MAX_STEPS);
   localparam int                USTEP_W   = ustep_w_f(MAX_STEPS);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

   seq_state_e        state_q, state_d;
   logic              started_q;
   logic              cf_q, cf_d;
   logic              zf_q, zf_d;
   logic [STEP_W-1:0] step_s;
   logic              en_s;
   logic              clr_s;
   logic              step_mode_s;
   logic [CTRL_W-1:0] ctrl_s;

`ifdef SEQ_SINGLE_STEP_EN
   assign step_mode_s = bus.STEP_MODE;
`else
   assign step_mode_s = 1'b0;
`endif

   // Next-state decode; the first edge after reset release keeps FETCH0
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH0: begin
            if (started_q) begin
               state_d = FETCH1;
            end else begin
               state_d = FETCH0;
            end
         end
         FETCH1: state_d = EXEC;
         EXEC: begin
            if (bus.UHLT) begin
               state_d = HALT;
            end else if (bus.UEND || (step_s == LAST_STEP)) begin
               if (step_mode_s) begin
                  state_d = HALT;
               end else begin
                  state_d = FETCH0;
               end
            end else begin
               state_d = EXEC;
            end
         end
         HALT: begin
            if (bus.RESUME) begin
               state_d = FETCH0;
            end else begin
               state_d = HALT;
            end
         end
         default: state_d = FETCH0;
      endcase
   end

   // Flags are captured once per instruction, as FETCH0 is left
   always_comb begin
      if ((state_q == FETCH0) && (state_d != FETCH0)) begin
         cf_d = bus.CF;
         zf_d = bus.ZF;
      end else begin
         cf_d = cf_q;
         zf_d = zf_q;
      end
   end

   // State and latched-flag registers
   always_ff @(negedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q   <= FETCH0;
         started_q <= 1'b0;
         cf_q      <= 1'b0;
         zf_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         started_q <= 1'b1;
         cf_q      <= cf_d;
         zf_q      <= zf_d;
      end
   end

   assign en_s  = (state_d == FETCH1) || (state_d == EXEC);
   assign clr_s = ~en_s;

   seq_step_counter #(
      .WIDTH (STEP_W)
   ) u_step_counter (
      .clk_i  (CLK),
      .rst_ni (RESETn),
      .clr_i  (clr_s),
      .en_i   (en_s),
      .cnt_o  (step_s)
   );

   // Control word select, forced idle while reset is held
   always_comb begin
      ctrl_s = IDLE_WORD;
      if (!RESETn) begin
         ctrl_s = IDLE_WORD;
      end else begin
         case (state_q)
            FETCH0:  ctrl_s = FETCH0_WORD;
            FETCH1:  ctrl_s = FETCH1_WORD;
            EXEC:    ctrl_s = bus.UWORD;
            HALT:    ctrl_s = IDLE_WORD;
            default: ctrl_s = IDLE_WORD;
         endcase
      end
   end

   assign bus.CTRL   = ctrl_s;
   assign bus.T0     = RESETn && (state_q == FETCH0);
   assign bus.HALTED = RESETn && (state_q == HALT);
   assign bus.STEP   = step_s;
   assign bus.UADDR  = {bus.OPCODE, cf_q, zf_q, USTEP_W'(step_s - STEP_W'(2))};

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer with an instruction-level reference model.
module tb_microsequencer;

   localparam int MAX_STEPS = 6;

   logic CLK;
   logic RESETn = 1'b1;

   microsequencer_if #(.OPCODE_W(4), .CTRL_W(16), .MAX_STEPS(MAX_STEPS)) bus ();

   microsequencer #(.OPCODE_W(4), .CTRL_W(16), .MAX_STEPS(MAX_STEPS)) dut (
      .CLK    (CLK),
      .RESETn (RESETn),
      .bus    (bus)
   );

   logic [15:0] rom_word [256];
   logic        rom_end  [256];
   logic        rom_hlt  [256];

   assign bus.UWORD = rom_word[bus.UADDR];
   assign bus.UEND  = rom_end[bus.UADDR];
   assign bus.UHLT  = rom_hlt[bus.UADDR];

   logic step_mode_b;
`ifdef SEQ_SINGLE_STEP_EN
   assign step_mode_b = bus.STEP_MODE;
`else
   assign step_mode_b = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   // Instruction-level model: m_step is the T-state index within the instruction
   int m_step  = 0;
   bit m_halt  = 1'b0;
   bit m_first = 1'b1;
   bit m_cf    = 1'b0;
   bit m_zf    = 1'b0;

   function automatic int maddr(input int op, input int cf, input int zf, input int step);
      return op * 16 + cf * 8 + zf * 4 + ((step - 2) & 3);
   endfunction

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(negedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         m_step <= 0; m_halt <= 1'b0; m_first <= 1'b1; m_cf <= 1'b0; m_zf <= 1'b0;
      end else if (m_first) begin
         m_first <= 1'b0;
      end else if (m_halt) begin
         if (bus.RESUME) begin
            m_halt <= 1'b0; m_step <= 0;
         end
      end else if (m_step == 0) begin
         m_cf <= bus.CF; m_zf <= bus.ZF; m_step <= 1;
      end else if (m_step == 1) begin
         m_step <= 2;
      end else if (rom_hlt[maddr(int'(bus.OPCODE), int'(m_cf), int'(m_zf), m_step)]) begin
         m_halt <= 1'b1; m_step <= 0;
      end else if (rom_end[maddr(int'(bus.OPCODE), int'(m_cf), int'(m_zf), m_step)]
                   || m_step == MAX_STEPS - 1) begin
         m_step <= 0;
         if (step_mode_b) m_halt <= 1'b1;
      end else begin
         m_step <= m_step + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   logic [15:0] e_ctrl;
   logic        e_t0;
   logic        e_halted;
   int          e_step;
   int          e_uaddr;

   // Per-cycle comparison against the model, one unit after the datapath edge
   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (!RESETn || m_halt) e_ctrl = 16'h0FFF;
         else if (m_step == 0) e_ctrl = 16'h0BF7;
         else if (m_step == 1) e_ctrl = 16'h1DFF;
         else e_ctrl = rom_word[maddr(int'(bus.OPCODE), int'(m_cf), int'(m_zf), m_step)];
         e_t0     = RESETn && !m_halt && (m_step == 0);
         e_halted = RESETn && m_halt;
         e_step   = m_step;
         e_uaddr  = maddr(int'(bus.OPCODE), int'(m_cf), int'(m_zf), m_step);
         chk("model_ctrl",   32'(bus.CTRL),   32'(e_ctrl));
         chk("model_t0",     32'(bus.T0),     32'(e_t0));
         chk("model_halted", 32'(bus.HALTED), 32'(e_halted));
         chk("model_step",   32'(bus.STEP),   32'(e_step));
         chk("model_uaddr",  32'(bus.UADDR),  32'(e_uaddr));
      end
   end

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   int exp_steps [7] = '{0, 1, 2, 3, 4, 5, 0};
   int n_t0;

   initial begin
      for (int a = 0; a < 256; a++) begin
         rom_word[a] = 16'hC000 | 16'(a);
         rom_end[a]  = 1'b0;
         rom_hlt[a]  = 1'b0;
      end
      for (int f = 0; f < 4; f++) begin
         rom_end[16 * 1 + f * 4] = 1'b1;
         rom_hlt[16 * 4 + f * 4 + 1] = 1'b1;
         rom_end[16 * 5 + f * 4] = 1'b1;
         rom_hlt[16 * 5 + f * 4] = 1'b1;
      end
      bus.OPCODE = 4'd1; bus.CF = 1'b0; bus.ZF = 1'b0; bus.RESUME = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
      bus.STEP_MODE = 1'b0;
`endif
      #1 RESETn = 1'b0;

      // Reset state, then release and the 3-cycle instruction stream
      tick();
      chk("rst_ctrl", 32'(bus.CTRL), 32'h0FFF);
      chk("rst_t0", 32'(bus.T0), 32'd0);
      chk("rst_halted", 32'(bus.HALTED), 32'd0);
      tick();
      RESETn = 1'b1;
      #1;
      chk("rel_ctrl", 32'(bus.CTRL), 32'h0BF7);
      chk("rel_t0", 32'(bus.T0), 32'd1);
      tick(); chk("hold_ctrl", 32'(bus.CTRL), 32'h0BF7);
      tick(); chk("f1_ctrl", 32'(bus.CTRL), 32'h1DFF);
      tick(); chk("ex_ctrl", 32'(bus.CTRL), 32'hC010);
      tick(); chk("t0_a", 32'(bus.T0), 32'd1);
      tick(); chk("t0_b", 32'(bus.T0), 32'd0);
      tick(); chk("ex2_ctrl", 32'(bus.CTRL), 32'hC010);
      tick(); chk("t0_c", 32'(bus.T0), 32'd1);

      // Full-length instruction: STEP 0..5 then back to 0
      bus.OPCODE = 4'd2;
      for (int i = 0; i < 7; i++) begin
         chk("step_seq", 32'(bus.STEP), 32'(exp_steps[i]));
         if (i >= 2 && i <= 5) chk("ustep_seq", 32'(bus.UADDR), 32'(32 + i - 2));
         if (i < 6) tick();
      end

      // CF latched at T0, dropped in T1
      bus.OPCODE = 4'd3; bus.CF = 1'b1;
      tick(); bus.CF = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("cf_latched", 32'(bus.UADDR), 32'(56 + i));
      end
      tick(); chk("t0_after_cf", 32'(bus.T0), 32'd1);

      // Halt at exec step 1, resume pulse
      bus.OPCODE = 4'd4;
      tick(); tick(); tick();
      chk("h_ex1_ctrl", 32'(bus.CTRL), 32'hC041);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("halted", 32'(bus.HALTED), 32'd1);
         chk("halt_ctrl", 32'(bus.CTRL), 32'h0FFF);
      end
      bus.RESUME = 1'b1;
      tick(); bus.RESUME = 1'b0;
      chk("resume_t0", 32'(bus.T0), 32'd1);
      chk("resume_halted", 32'(bus.HALTED), 32'd0);

      // UHLT with UEND, RESUME held high throughout
      bus.OPCODE = 4'd5; bus.RESUME = 1'b1;
      tick(); chk("ign_resume_step", 32'(bus.STEP), 32'd1);
      tick(); chk("he_ctrl", 32'(bus.CTRL), 32'hC050);
      tick(); chk("he_halted", 32'(bus.HALTED), 32'd1);
      tick(); chk("he_t0", 32'(bus.T0), 32'd1);
      bus.RESUME = 1'b0;

`ifdef SEQ_SINGLE_STEP_EN
      // Single-step: one instruction per RESUME
      bus.OPCODE = 4'd1; bus.STEP_MODE = 1'b1;
      tick(); tick(); tick();
      chk("ss_halted", 32'(bus.HALTED), 32'd1);
      tick();
      n_t0 = 0;
      for (int k = 0; k < 3; k++) begin
         bus.RESUME = 1'b1;
         tick(); bus.RESUME = 1'b0;
         if (bus.T0) n_t0++;
         for (int j = 0; j < 4; j++) begin
            tick();
            if (bus.T0) n_t0++;
         end
      end
      chk("ss_t0_count", 32'(n_t0), 32'd3);
      bus.STEP_MODE = 1'b0; bus.RESUME = 1'b1;
      tick(); bus.RESUME = 1'b0;
      chk("ss_exit_t0", 32'(bus.T0), 32'd1);
`endif

      // Reset asserted mid-execute at STEP 3
      bus.OPCODE = 4'd2;
      tick(); tick(); tick();
      chk("pre_rst_step", 32'(bus.STEP), 32'd3);
      #1 RESETn = 1'b0;
      #1;
      chk("mid_rst_ctrl", 32'(bus.CTRL), 32'h0FFF);
      chk("mid_rst_step", 32'(bus.STEP), 32'd0);
      chk("mid_rst_halted", 32'(bus.HALTED), 32'd0);
      chk("mid_rst_t0", 32'(bus.T0), 32'd0);
      tick(); tick();
      RESETn = 1'b1;
      #1;
      chk("rerel_ctrl", 32'(bus.CTRL), 32'h0BF7);
      tick(); tick();
      chk("rerel_f1", 32'(bus.CTRL), 32'h1DFF);
      repeat (10) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
